// File: rtl/gshare_spec_predictor_if.sv
// Prediction and update bus between fetch/execute (master) and the gshare predictor (slave).
interface gshare_spec_predictor_if #(
    parameter int unsigned IDX_WIDTH  = 8,
    parameter int unsigned HIST_WIDTH = 8
);
    logic                  pred_valid;
    logic [31:0]           pred_pc;
    logic                  pred_taken;
    logic [IDX_WIDTH-1:0]  pred_idx;
    logic [HIST_WIDTH-1:0] pred_hist;

    logic                  upd_valid;
    logic [IDX_WIDTH-1:0]  upd_idx;
    logic                  upd_taken;
    logic                  upd_mispredict;
    logic [HIST_WIDTH-1:0] upd_hist;

    logic [31:0]           perf_updates;
    logic [31:0]           perf_mispredicts;

    modport master (
        output pred_valid, pred_pc,
        output upd_valid, upd_idx, upd_taken, upd_mispredict, upd_hist,
        input  pred_taken, pred_idx, pred_hist,
        input  perf_updates, perf_mispredicts
    );

    modport slave (
        input  pred_valid, pred_pc,
        input  upd_valid, upd_idx, upd_taken, upd_mispredict, upd_hist,
        output pred_taken, pred_idx, pred_hist,
        output perf_updates, perf_mispredicts
    );
endinterface

// File: rtl/gshare_spec_predictor.sv
// Gshare direction predictor with speculative global history and checkpoint restore.
// Optional performance counters are enabled by defining GSHARE_PERF_CNT_EN.
module gshare_spec_predictor #(
    parameter int unsigned IDX_WIDTH  = 8,
    parameter int unsigned HIST_WIDTH = 8,
    parameter int unsigned CTR_WIDTH  = 2,
    parameter int unsigned PC_LSB     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    gshare_spec_predictor_if.slave bp
);
    localparam int unsigned DEPTH = 1 << IDX_WIDTH;
    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
    localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);

    logic [HIST_WIDTH-1:0] spec_hist_q;
    logic [HIST_WIDTH-1:0] spec_hist_d;
    logic [CTR_WIDTH-1:0]  ctr_q [DEPTH];
    logic [CTR_WIDTH-1:0]  ctr_d [DEPTH];
    logic [IDX_WIDTH-1:0]  idx_c;
    logic [CTR_WIDTH-1:0]  upd_ctr_c;
    logic [CTR_WIDTH-1:0]  upd_ctr_next_c;
    logic                  pc_unused;

    // Index and prediction read the registered table, so a same-cycle update is not visible yet.
    assign idx_c         = bp.pred_pc[PC_LSB +: IDX_WIDTH] ^ IDX_WIDTH'(spec_hist_q);
    assign bp.pred_idx   = idx_c;
    assign bp.pred_taken = ctr_q[idx_c][CTR_WIDTH-1];
    assign bp.pred_hist  = spec_hist_q;
    assign pc_unused     = ^bp.pred_pc;

    // Truncating {hist, bit} keeps the low HIST_WIDTH bits, which also covers HIST_WIDTH=1.
    always_comb begin
        spec_hist_d = spec_hist_q;
        if (bp.upd_valid && bp.upd_mispredict) begin
            spec_hist_d = HIST_WIDTH'({bp.upd_hist, bp.upd_taken});
        end else if (bp.pred_valid) begin
            spec_hist_d = HIST_WIDTH'({spec_hist_q, bp.pred_taken});
        end
    end

    assign upd_ctr_c = ctr_q[bp.upd_idx];

    always_comb begin
        upd_ctr_next_c = upd_ctr_c;
        if (bp.upd_taken) begin
            if (upd_ctr_c != CTR_MAX) begin
                upd_ctr_next_c = upd_ctr_c + CTR_WIDTH'(1);
            end
        end else if (upd_ctr_c != '0) begin
            upd_ctr_next_c = upd_ctr_c - CTR_WIDTH'(1);
        end
    end

    always_comb begin
        ctr_d = ctr_q;
        if (bp.upd_valid) begin
            ctr_d[bp.upd_idx] = upd_ctr_next_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spec_hist_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else begin
            spec_hist_q <= spec_hist_d;
            ctr_q       <= ctr_d;
        end
    end

`ifdef GSHARE_PERF_CNT_EN
    logic [31:0] perf_upd_q;
    logic [31:0] perf_upd_d;
    logic [31:0] perf_mis_q;
    logic [31:0] perf_mis_d;

    // Saturating event counters for resolved updates and mispredicts.
    always_comb begin
        perf_upd_d = perf_upd_q;
        perf_mis_d = perf_mis_q;
        if (bp.upd_valid && (perf_upd_q != 32'hFFFF_FFFF)) begin
            perf_upd_d = perf_upd_q + 32'd1;
        end
        if (bp.upd_valid && bp.upd_mispredict && (perf_mis_q != 32'hFFFF_FFFF)) begin
            perf_mis_d = perf_mis_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_upd_q <= '0;
            perf_mis_q <= '0;
        end else begin
            perf_upd_q <= perf_upd_d;
            perf_mis_q <= perf_mis_d;
        end
    end

    assign bp.perf_updates     = perf_upd_q;
    assign bp.perf_mispredicts = perf_mis_q;
`else
    assign bp.perf_updates     = '0;
    assign bp.perf_mispredicts = '0;
`endif

endmodule

// File: doc/gshare_spec_predictor.md
Name: gshare_spec_predictor

Overview:
- Parametrised gshare direction predictor: global history XORed with PC bits indexes a table of N-bit saturating counters.
- Sits beside fetch and returns a same-cycle taken/not-taken prediction.
- Updates the global history speculatively at predict time.
- Accepts resolved outcomes from execute through a separate update port, including history restore on mispredict.

Parameters:
- IDX_WIDTH, 8, log2 of counter table depth; the table has 2^IDX_WIDTH entries.
- HIST_WIDTH, 8, global history length; legal range 1 to IDX_WIDTH.
- CTR_WIDTH, 2, saturating counter width; legal range 1 to 4.
- PC_LSB, 2, lowest PC bit used in the index.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- pred_valid  in  1  fetch requests a prediction this cycle
- pred_pc  in  32  PC of the instruction being predicted
- pred_taken  out  1  predicted direction (combinational)
- pred_idx  out  IDX_WIDTH  table index used; carried down the pipeline with the branch
- pred_hist  out  HIST_WIDTH  speculative history before this prediction; carried as a checkpoint
- upd_valid  in  1  resolved branch update
- upd_idx  in  IDX_WIDTH  index returned from pred_idx
- upd_taken  in  1  resolved direction
- upd_mispredict  in  1  resolved direction differs from the prediction
- upd_hist  in  HIST_WIDTH  checkpoint returned from pred_hist
- perf_updates  out  32  resolved-update count (see Optional Feature)
- perf_mispredicts  out  32  mispredict count (see Optional Feature)

Behaviour:
- Reset:
  - rst is asynchronous and active-high; it takes effect immediately, with no clock edge required.
  - Clears the speculative history to 0.
  - Sets every counter to weakly-not-taken, value 2^(CTR_WIDTH-1)-1. For CTR_WIDTH=1 this value is 0.
  - Clears the perf counters.
  - pred_taken therefore reads 0 directly after reset.
- Index:
  - pred_idx = pred_pc[PC_LSB +: IDX_WIDTH] XOR zero-extended spec_hist.
  - History is aligned to the LSB of the index.
- Prediction:
  - pred_taken = MSB of counter[pred_idx].
  - Purely combinational, zero latency.
  - Valid regardless of pred_valid; pred_valid only gates the history update.
  - pred_hist = current spec_hist.
- Speculative history, on a clock edge with pred_valid=1 and no restore:
  - spec_hist <= {spec_hist[HIST_WIDTH-2:0], pred_taken}.
  - For HIST_WIDTH=1: spec_hist <= pred_taken.
- Restore, on a clock edge with upd_valid=1 and upd_mispredict=1:
  - spec_hist <= {upd_hist[HIST_WIDTH-2:0], upd_taken}.
  - Takes priority over a same-cycle pred_valid shift; that prediction is discarded by the pipeline anyway.
  - Neither event: spec_hist holds.
- Counter update, on a clock edge with upd_valid=1:
  - counter[upd_idx] increments if upd_taken=1, saturating at 2^CTR_WIDTH-1.
  - Otherwise it decrements, saturating at 0.
  - Arithmetic is CTR_WIDTH wide and never wraps.
  - Counters are only written via the update port; prediction never modifies them.
- Read-during-write:
  - When pred_idx==upd_idx in the same cycle, pred_taken reflects the pre-update value.
  - The new value is visible from the next cycle.
- upd_mispredict with upd_valid=0 is ignored.
- One update per cycle; back-to-back updates to the same index accumulate with no lost increments.

Optional Feature:
- Macro GSHARE_PERF_CNT_EN.
- Defined:
  - perf_updates increments on each cycle with upd_valid=1.
  - perf_mispredicts increments on each cycle with upd_valid=1 and upd_mispredict=1.
  - Both saturate at 32'hFFFF_FFFF.
  - Both clear on rst.
- Undefined:
  - Counter logic is absent.
  - Both outputs are tied to 0, so the port list is unchanged.

Test Plan:
- Defaults apply to all scenarios: IDX_WIDTH=8, HIST_WIDTH=8, CTR_WIDTH=2, PC_LSB=2.
- Reset: assert rst without clocking, pred_pc=0x100 -> pred_idx=0x40, pred_taken=0, pred_hist=0x00. The perf outputs read 0.
- Saturation: three updates with upd_idx=0x40, upd_taken=1 -> counter 1→2→3→3. pred_taken=1 from the cycle after the first update. One not-taken update -> counter 2, pred_taken still 1. Five not-taken updates -> counter reaches 0 and holds.
- Speculative shift:
  - Train idx 0x40 to 3, then hold pred_valid=1 with pred_pc=0x100.
  - Cycle 1: idx 0x40, taken, hist 0x00→0x01.
  - Cycle 2: idx 0x41, counter 1, not-taken, hist→0x02.
- Restore priority: same cycle pred_valid=1, upd_valid=1, upd_mispredict=1, upd_hist=0x5A, upd_taken=1 -> next cycle pred_hist=0xB5. With pred_pc=0x0, pred_idx=0xB5.
- Read-during-write: counter[0x40]=1, pred_pc=0x100, hist 0, while upd_idx=0x40 and upd_taken=1 -> pred_taken=0 that cycle and 1 the next cycle.
- Reset mid-operation and perf:
  - With the macro on: 5 updates including 2 mispredicts -> perf_updates=5, perf_mispredicts=2.
  - Then assert rst between clock edges -> history, counters and perf outputs clear immediately.
